// File: rtl/uart_tx_fifo_prescaled_if.sv
// rtl/uart_tx_fifo_prescaled_if.sv - producer ready/valid handshake into the UART TX FIFO
interface uart_tx_fifo_prescaled_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  data_ready;

    modport master (output data_valid, output parallel_data, input data_ready);
    modport slave  (input data_valid, input parallel_data, output data_ready);
endinterface

// File: rtl/uart_tx_fifo_prescaled.sv
// rtl/uart_tx_fifo_prescaled.sv - FIFO-buffered UART transmitter with programmable clocks-per-bit
module uart_tx_fifo_prescaled #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          parity_enable,
    input  logic                          parity_type,
    input  logic                          two_stop_bits,
    input  logic [PRESCALE_WIDTH-1:0]     prescale,
    uart_tx_fifo_prescaled_if.slave       prod,
    output logic                          serial_data_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]     shreg, sh_next, head;
    logic [PRESCALE_WIDTH-1:0] pre_cnt, p_lat, p_eff;
    logic [BIT_W-1:0]          bit_cnt;
    logic                      pe_lat, ts_lat, par_lat;
    logic                      push, pop, fifo_empty, stop_last;

    assign prod.data_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_empty      = (fifo_count == '0);
    assign push            = prod.data_valid & prod.data_ready;
    assign head            = mem[rd_ptr];
    assign sh_next         = shreg >> 1;
    assign p_eff           = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
    assign stop_last       = !ts_lat || (bit_cnt != '0);
    // Pop either from idle or on the very last stop cycle so frames run back-to-back.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || (state == STOP && pre_cnt == '0 && stop_last));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= prod.parallel_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            serial_data_out <= 1'b1;
            busy            <= 1'b0;
            pre_cnt         <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            p_lat           <= PRESCALE_WIDTH'(1);
            pe_lat          <= 1'b0;
            ts_lat          <= 1'b0;
            par_lat         <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                START: begin
                    if (pre_cnt == '0) begin
                        pre_cnt         <= p_lat - PRESCALE_WIDTH'(1);
                        bit_cnt         <= '0;
                        serial_data_out <= shreg[0];
                        state           <= DATA;
                    end else begin
                        pre_cnt <= pre_cnt - PRESCALE_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (pre_cnt == '0) begin
                        pre_cnt <= p_lat - PRESCALE_WIDTH'(1);
                        if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            if (pe_lat) begin
                                serial_data_out <= par_lat;
                                state           <= PARITY;
                            end else begin
                                serial_data_out <= 1'b1;
                                state           <= STOP;
                            end
                        end else begin
                            bit_cnt         <= bit_cnt + BIT_W'(1);
                            shreg           <= sh_next;
                            serial_data_out <= sh_next[0];
                        end
                    end else begin
                        pre_cnt <= pre_cnt - PRESCALE_WIDTH'(1);
                    end
                end
                PARITY: begin
                    if (pre_cnt == '0) begin
                        pre_cnt         <= p_lat - PRESCALE_WIDTH'(1);
                        bit_cnt         <= '0;
                        serial_data_out <= 1'b1;
                        state           <= STOP;
                    end else begin
                        pre_cnt <= pre_cnt - PRESCALE_WIDTH'(1);
                    end
                end
                STOP: begin
                    // bit_cnt doubles as the stop-bit index here
                    if (pre_cnt == '0) begin
                        if (!stop_last) begin
                            bit_cnt <= BIT_W'(1);
                            pre_cnt <= p_lat - PRESCALE_WIDTH'(1);
                        end else begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        pre_cnt <= pre_cnt - PRESCALE_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                shreg           <= head;
                par_lat         <= (^head) ^ parity_type;
                pe_lat          <= parity_enable;
                ts_lat          <= two_stop_bits;
                p_lat           <= p_eff;
                pre_cnt         <= p_eff - PRESCALE_WIDTH'(1);
                bit_cnt         <= '0;
                serial_data_out <= 1'b0;
                busy            <= 1'b1;
                state           <= START;
            end
        end
    end
endmodule
